// File: rtl/reg_status_file_mp.sv
// reg_status_file_mp
//   Multi-port architectural register file with per-register rename status
//   (busy bit + producing ROB tag) for the Tomasulo/ROB core.
//   Dispatch renames up to ISSUE_W destinations per cycle. Each dispatch slot
//   reads two operands with full bypass of same-cycle renames in older slots
//   and same-cycle commits. The ROB retires up to COMMIT_W results per cycle.
//   A rollback clears every busy bit in one cycle.
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   iss_valid/rd/rob_id/rs1/rs2    dispatch slots (slot 0 oldest), flattened
//   rs1_*/rs2_* (val, busy, tag)   combinational operand read results per slot
//   cmt_valid/rd/rob_id/data       commit slots (slot 0 oldest), flattened
//   rollback                       mispredict flush
module reg_status_file_mp #(
  parameter int REG_NUM  = 32,
  parameter int DATA_W   = 32,
  parameter int ROB_W    = 4,
  parameter int ISSUE_W  = 2,
  parameter int COMMIT_W = 2,
  localparam int IDX_W   = $clog2(REG_NUM)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ISSUE_W-1:0]           iss_valid,
  input  logic [ISSUE_W*IDX_W-1:0]     iss_rd,
  input  logic [ISSUE_W*ROB_W-1:0]     iss_rob_id,
  input  logic [ISSUE_W*IDX_W-1:0]     iss_rs1,
  input  logic [ISSUE_W*IDX_W-1:0]     iss_rs2,
  output logic [ISSUE_W*DATA_W-1:0]    rs1_val,
  output logic [ISSUE_W-1:0]           rs1_busy,
  output logic [ISSUE_W*ROB_W-1:0]     rs1_tag,
  output logic [ISSUE_W*DATA_W-1:0]    rs2_val,
  output logic [ISSUE_W-1:0]           rs2_busy,
  output logic [ISSUE_W*ROB_W-1:0]     rs2_tag,
  input  logic [COMMIT_W-1:0]          cmt_valid,
  input  logic [COMMIT_W*IDX_W-1:0]    cmt_rd,
  input  logic [COMMIT_W*ROB_W-1:0]    cmt_rob_id,
  input  logic [COMMIT_W*DATA_W-1:0]   cmt_data,
  input  logic                         rollback
);

  logic [DATA_W-1:0] v_q   [REG_NUM];
  logic              b_q   [REG_NUM];
  logic [ROB_W-1:0]  t_q   [REG_NUM];
  logic [DATA_W-1:0] v_nxt [REG_NUM];
  logic              b_nxt [REG_NUM];
  logic [ROB_W-1:0]  t_nxt [REG_NUM];

  // Operand read: priority x0 > older-slot rename > commit bypass > state.
  // Slots are scanned oldest to youngest so the youngest match wins.
  always_comb begin
    logic [IDX_W-1:0]  rs;
    logic [DATA_W-1:0] val;
    logic              busy;
    logic [ROB_W-1:0]  tag;
    logic              hit_c;
    rs1_val  = '0;
    rs1_busy = '0;
    rs1_tag  = '0;
    rs2_val  = '0;
    rs2_busy = '0;
    rs2_tag  = '0;
    for (int j = 0; j < ISSUE_W; j++) begin
      for (int op = 0; op < 2; op++) begin
        rs    = (op == 0) ? iss_rs1[j*IDX_W +: IDX_W] : iss_rs2[j*IDX_W +: IDX_W];
        val   = v_q[rs];
        busy  = b_q[rs];
        tag   = t_q[rs];
        hit_c = 1'b0;
        for (int k = 0; k < COMMIT_W; k++) begin
          if (cmt_valid[k] && cmt_rd[k*IDX_W +: IDX_W] == rs) begin
            hit_c = 1'b1;
            val   = cmt_data[k*DATA_W +: DATA_W];
            // Only the commit that matches the current mapping frees the reg.
            if (rollback || (b_q[rs] && t_q[rs] == cmt_rob_id[k*ROB_W +: ROB_W]))
              busy = 1'b0;
            else
              busy = b_q[rs];
          end
        end
        if (!hit_c && rollback)
          busy = 1'b0;
        // A slot only sees renames from strictly older slots in its group.
        for (int i = 0; i < j; i++) begin
          if (iss_valid[i] && !rollback && iss_rd[i*IDX_W +: IDX_W] == rs) begin
            busy = 1'b1;
            tag  = iss_rob_id[i*ROB_W +: ROB_W];
          end
        end
        if (rs == '0) begin
          val  = '0;
          busy = 1'b0;
          tag  = '0;
        end
        if (op == 0) begin
          rs1_val[j*DATA_W +: DATA_W] = val;
          rs1_busy[j]                 = busy;
          rs1_tag[j*ROB_W +: ROB_W]   = tag;
        end else begin
          rs2_val[j*DATA_W +: DATA_W] = val;
          rs2_busy[j]                 = busy;
          rs2_tag[j*ROB_W +: ROB_W]   = tag;
        end
      end
    end
  end

  // Next state: commits first, then rollback or issue renames override the
  // busy/tag result of any commit on the same register.
  always_comb begin
    logic [IDX_W-1:0] rd;
    for (int r = 0; r < REG_NUM; r++) begin
      v_nxt[r] = v_q[r];
      b_nxt[r] = b_q[r];
      t_nxt[r] = t_q[r];
    end
    for (int k = 0; k < COMMIT_W; k++) begin
      rd = cmt_rd[k*IDX_W +: IDX_W];
      if (cmt_valid[k] && rd != '0) begin
        v_nxt[rd] = cmt_data[k*DATA_W +: DATA_W];
        b_nxt[rd] = (t_q[rd] == cmt_rob_id[k*ROB_W +: ROB_W]) ? 1'b0 : b_q[rd];
      end
    end
    if (rollback) begin
      for (int r = 0; r < REG_NUM; r++)
        b_nxt[r] = 1'b0;
    end else begin
      for (int i = 0; i < ISSUE_W; i++) begin
        rd = iss_rd[i*IDX_W +: IDX_W];
        if (iss_valid[i] && rd != '0) begin
          b_nxt[rd] = 1'b1;
          t_nxt[rd] = iss_rob_id[i*ROB_W +: ROB_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < REG_NUM; r++) begin
        v_q[r] <= '0;
        b_q[r] <= 1'b0;
        t_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < REG_NUM; r++) begin
        v_q[r] <= v_nxt[r];
        b_q[r] <= b_nxt[r];
        t_q[r] <= t_nxt[r];
      end
    end
  end

endmodule

// File: tb/tb_reg_status_file_mp.sv
module tb_reg_status_file_mp;
  localparam int REG_NUM = 32, DATA_W = 32, ROB_W = 4, ISSUE_W = 2, COMMIT_W = 2;
  localparam int IDX_W = 5;

  logic clk = 1'b0;
  logic rst;
  logic [ISSUE_W-1:0]         iss_valid;
  logic [ISSUE_W*IDX_W-1:0]   iss_rd, iss_rs1, iss_rs2;
  logic [ISSUE_W*ROB_W-1:0]   iss_rob_id;
  logic [ISSUE_W*DATA_W-1:0]  rs1_val, rs2_val;
  logic [ISSUE_W-1:0]         rs1_busy, rs2_busy;
  logic [ISSUE_W*ROB_W-1:0]   rs1_tag, rs2_tag;
  logic [COMMIT_W-1:0]        cmt_valid;
  logic [COMMIT_W*IDX_W-1:0]  cmt_rd;
  logic [COMMIT_W*ROB_W-1:0]  cmt_rob_id;
  logic [COMMIT_W*DATA_W-1:0] cmt_data;
  logic                       rollback;

  reg_status_file_mp #(.REG_NUM(REG_NUM), .DATA_W(DATA_W), .ROB_W(ROB_W),
                       .ISSUE_W(ISSUE_W), .COMMIT_W(COMMIT_W)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_rob_id(iss_rob_id),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .rs1_val(rs1_val), .rs1_busy(rs1_busy), .rs1_tag(rs1_tag),
    .rs2_val(rs2_val), .rs2_busy(rs2_busy), .rs2_tag(rs2_tag),
    .cmt_valid(cmt_valid), .cmt_rd(cmt_rd), .cmt_rob_id(cmt_rob_id),
    .cmt_data(cmt_data), .rollback(rollback)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] exp;
  } exp_t;
  exp_t sb[$];
  int n_cmp = 0;
  int n_fail = 0;

  task automatic idle();
    iss_valid = '0; iss_rd = '0; iss_rob_id = '0; iss_rs1 = '0; iss_rs2 = '0;
    cmt_valid = '0; cmt_rd = '0; cmt_rob_id = '0; cmt_data = '0;
    rollback = 1'b0;
  endtask

  task automatic set_iss(int s, int rd, int rob);
    iss_valid[s] = 1'b1;
    iss_rd[s*IDX_W +: IDX_W] = IDX_W'(rd);
    iss_rob_id[s*ROB_W +: ROB_W] = ROB_W'(rob);
  endtask

  task automatic set_rs(int s, int r1, int r2);
    iss_rs1[s*IDX_W +: IDX_W] = IDX_W'(r1);
    iss_rs2[s*IDX_W +: IDX_W] = IDX_W'(r2);
  endtask

  task automatic set_cmt(int s, int rd, int rob, logic [31:0] d);
    cmt_valid[s] = 1'b1;
    cmt_rd[s*IDX_W +: IDX_W] = IDX_W'(rd);
    cmt_rob_id[s*ROB_W +: ROB_W] = ROB_W'(rob);
    cmt_data[s*DATA_W +: DATA_W] = d;
  endtask

  task automatic push(string name, logic [63:0] e);
    exp_t x;
    x.name = name;
    x.exp  = e;
    sb.push_back(x);
  endtask

  task automatic chk(logic [63:0] obs);
    exp_t x;
    n_cmp++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0h, required an entry", obs);
    end else begin
      x = sb.pop_front();
      assert (obs === x.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %0h, expected %0h", x.name, obs, x.exp);
      end
    end
  endtask

  function automatic logic [63:0] v1(int s);  return 64'(rs1_val[s*DATA_W +: DATA_W]); endfunction
  function automatic logic [63:0] b1(int s);  return 64'(rs1_busy[s]); endfunction
  function automatic logic [63:0] t1(int s);  return 64'(rs1_tag[s*ROB_W +: ROB_W]); endfunction
  function automatic logic [63:0] v2(int s);  return 64'(rs2_val[s*DATA_W +: DATA_W]); endfunction
  function automatic logic [63:0] b2(int s);  return 64'(rs2_busy[s]); endfunction
  function automatic logic [63:0] t2(int s);  return 64'(rs2_tag[s*ROB_W +: ROB_W]); endfunction

  // Inputs change just after the falling edge; outputs are sampled 2 time
  // units later, well clear of the rising edge.
  task automatic tick();
    @(negedge clk);
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state of x5
    idle(); set_rs(0, 5, 5);
    push("rst_x5_val", 0); push("rst_x5_busy", 0); push("rst_x5_tag", 0);
    #2; chk(v1(0)); chk(b1(0)); chk(t2(0));

    // Commit x5 while not busy, bypass and state
    tick(); set_cmt(0, 5, 3, 32'h1234); set_rs(0, 5, 0);
    push("cmt_byp_val", 32'h1234); push("cmt_byp_busy", 0);
    #2; chk(v1(0)); chk(b1(0));
    tick(); set_rs(0, 5, 0);
    push("x5_val", 32'h1234); push("x5_busy", 0);
    #2; chk(v1(0)); chk(b1(0));

    // Intra-group forward: slot0 renames x7, slot1 reads x7
    tick(); set_iss(0, 7, 2); set_rs(0, 7, 0); set_rs(1, 7, 7);
    push("self_rd_busy", 0); push("fwd_busy", 1); push("fwd_tag", 2); push("fwd_rs2_busy", 1);
    #2; chk(b1(0)); chk(b1(1)); chk(t1(1)); chk(b2(1));
    tick(); set_rs(0, 7, 0);
    push("x7_busy", 1); push("x7_tag", 2);
    #2; chk(b1(0)); chk(t1(0));

    // x9 busy with tag 4, then matching commit while being read
    tick(); set_iss(0, 9, 4);
    tick(); set_cmt(1, 9, 4, 32'hAA); set_rs(0, 9, 0);
    push("x9_cmt_val", 32'hAA); push("x9_cmt_busy", 0);
    #2; chk(v1(0)); chk(b1(0));
    tick(); set_rs(0, 0, 9);
    push("x9_free_val", 32'hAA); push("x9_free_busy", 0);
    #2; chk(v2(0)); chk(b2(0));

    // Matching commit and a new rename of the same reg in one cycle
    tick(); set_iss(0, 9, 4);
    tick(); set_cmt(0, 9, 4, 32'hBB); set_iss(0, 9, 6);
    tick(); set_rs(1, 9, 0);
    push("x9_ren_val", 32'hBB); push("x9_ren_busy", 1); push("x9_ren_tag", 6);
    #2; chk(v1(1)); chk(b1(1)); chk(t1(1));

    // Two slots rename x3, youngest wins; stale commit keeps it busy
    tick(); set_iss(0, 3, 1); set_iss(1, 3, 5);
    tick(); set_rs(0, 3, 0);
    push("x3_tag", 5); push("x3_busy", 1);
    #2; chk(t1(0)); chk(b1(0));
    tick(); set_cmt(0, 3, 1, 32'h33); set_rs(0, 3, 0);
    push("stale_byp_val", 32'h33); push("stale_byp_busy", 1); push("stale_byp_tag", 5);
    #2; chk(v1(0)); chk(b1(0)); chk(t1(0));
    tick(); set_rs(0, 3, 0);
    push("x3_stale_val", 32'h33); push("x3_stale_busy", 1); push("x3_stale_tag", 5);
    #2; chk(v1(0)); chk(b1(0)); chk(t1(0));

    // Rollback with an issue and a commit in the same cycle
    tick(); rollback = 1'b1; set_iss(0, 4, 7); set_cmt(0, 8, 9, 32'h55);
    set_rs(0, 3, 0); set_rs(1, 4, 0);
    push("rb_x3_busy", 0); push("rb_x4_fwd_busy", 0);
    #2; chk(b1(0)); chk(b1(1));
    tick(); set_rs(0, 4, 3); set_rs(1, 8, 9);
    push("rb_x4_busy", 0); push("rb_x3_busy_q", 0); push("rb_x8_val", 32'h55);
    push("rb_x8_busy", 0); push("rb_x9_busy", 0); push("rb_x9_tag_kept", 6);
    #2; chk(b1(0)); chk(b2(0)); chk(v1(1)); chk(b1(1)); chk(b2(1)); chk(t2(1));

    // x0: renames and commits are dropped
    tick(); set_iss(0, 0, 3); set_cmt(0, 0, 3, 32'hDEAD); set_rs(1, 0, 0);
    push("x0_fwd_busy", 0); push("x0_val", 0);
    #2; chk(b1(1)); chk(v2(1));
    tick(); set_rs(0, 0, 0);
    push("x0_busy_q", 0); push("x0_val_q", 0);
    #2; chk(b1(0)); chk(v1(0));

    // Two commits to one reg: youngest data lands
    tick(); set_cmt(0, 11, 1, 32'h1); set_cmt(1, 11, 2, 32'h2); set_rs(0, 11, 0);
    push("dual_cmt_byp", 2);
    #2; chk(v1(0));
    tick(); set_rs(0, 11, 0);
    push("dual_cmt_val", 2);
    #2; chk(v1(0));

    // Reset mid-operation discards in-flight events
    tick(); rst = 1'b1; set_iss(0, 10, 2); set_cmt(0, 12, 0, 32'h77);
    tick(); rst = 1'b0; set_rs(0, 10, 12); set_rs(1, 5, 0);
    push("rst2_x10_busy", 0); push("rst2_x12_val", 0); push("rst2_x5_val", 0);
    #2; chk(b1(0)); chk(v2(0)); chk(v1(1));

    n_cmp++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d left, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end
endmodule
